// File: rtl/pll_seq_pkg.sv
// ---------------------------------------------------------------------------
// pll_seq_pkg
// Shared types and helpers for the system PLL lock sequencer.
//   state_e    : sequencer states, also exported on the debug state port
//   cnt_width(): width of the single shared cycle counter, sized from the
//                largest count the sequencer ever has to reach
// ---------------------------------------------------------------------------
package pll_seq_pkg;

  typedef enum logic [2:0] {
    RESET_PLL = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RELEASE   = 3'd3,
    RUN       = 3'd4,
    FAULT     = 3'd5
  } state_e;

  // The counter only ever holds values up to (largest count - 1), so
  // $clog2 of the largest count is enough; never narrower than one bit.
  function automatic int cnt_width(input int rst_pulse, input int timeout,
                                   input int stable, input int release_span);
    int m;
    m = rst_pulse;
    if (timeout > m)      m = timeout;
    if (stable > m)       m = stable;
    if (release_span > m) m = release_span;
    return (m <= 1) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// ---------------------------------------------------------------------------
// sync_2ff
// Two-flop synchronizer for a single asynchronous level, reset value 0.
// Ports:
//   clk_i  : destination clock
//   rst_i  : synchronous active-high reset
//   d_i    : asynchronous input level
//   q_o    : synchronized level, two clk_i cycles of latency
// ---------------------------------------------------------------------------
module sync_2ff (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/pll_sys_lock_sequencer.sv
// ---------------------------------------------------------------------------
// pll_sys_lock_sequencer
// Brings up the system PLL: pulses the PLL reset, waits for lock with a
// timeout and bounded retries, qualifies lock stability, then releases the
// per-output-domain resets one after another. Any loss of lock after
// release, or a software relock request, restarts the whole sequence.
//
// Ports (all in the refclk domain except pll_locked):
//   refclk      : reference clock, sole clock of this block
//   rst         : synchronous active-high reset
//   pll_locked  : PLL lock flag, asynchronous, synchronized internally
//   relock_req  : single-cycle pulse requesting a full restart
//   pll_rst     : PLL reset, active high
//   domain_rst  : per-domain resets, active high; consumers re-synchronize
//                 the deassertion into their own clock
//   ready       : all domains released and lock qualified
//   fault       : MAX_RETRIES attempts timed out, held until relock/rst
//   retry_cnt   : failed lock attempts in the current sequence
//   state_dbg   : current FSM state, for debug and checkers
//
// Interface note: there is no valid/ready handshake here. relock_req is a
// one-cycle strobe that is acted on in the cycle it is high; pll_locked is a
// level. All outputs are registered from the next-state decision, so they
// change one cycle after the FSM decides.
// ---------------------------------------------------------------------------
module pll_sys_lock_sequencer
  import pll_seq_pkg::*;
#(
  parameter int NUM_DOMAINS         = 4,
  parameter int RST_PULSE_CYCLES    = 500,
  parameter int LOCK_TIMEOUT_CYCLES = 50000,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int STAGGER_CYCLES      = 16,
  parameter int MAX_RETRIES         = 3
) (
  input  logic                                 refclk,
  input  logic                                 rst,
  input  logic                                 pll_locked,
  input  logic                                 relock_req,
  output logic                                 pll_rst,
  output logic [NUM_DOMAINS-1:0]               domain_rst,
  output logic                                 ready,
  output logic                                 fault,
  output logic [$clog2(MAX_RETRIES+1)-1:0]     retry_cnt,
  output state_e                               state_dbg
);

  localparam int RW      = $clog2(MAX_RETRIES + 1);
  localparam int REL_LEN = NUM_DOMAINS * STAGGER_CYCLES;
  localparam int CNT_W   = cnt_width(RST_PULSE_CYCLES, LOCK_TIMEOUT_CYCLES,
                                     LOCK_STABLE_CYCLES, REL_LEN);

  // Terminal counter values: each state lasts exactly its count in cycles.
  localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] REL_LAST     = CNT_W'(REL_LEN - 1);
  localparam logic [RW-1:0]    RETRY_MAX    = RW'(MAX_RETRIES);

  // -------------------------------------------------------------------------
  // Lock synchronizer: the FSM only ever looks at lk.
  // -------------------------------------------------------------------------
  logic lk;

  sync_2ff u_lock_sync (
    .clk_i (refclk),
    .rst_i (rst),
    .d_i   (pll_locked),
    .q_o   (lk)
  );

  // -------------------------------------------------------------------------
  // State and registered outputs
  // -------------------------------------------------------------------------
  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [RW-1:0]          retry_q, retry_d;
  logic                   pll_rst_q, pll_rst_d;
  logic [NUM_DOMAINS-1:0] dom_rst_q, dom_rst_d;
  logic                   ready_q, ready_d;
  logic                   fault_q, fault_d;
  logic                   restart;

  always_ff @(posedge refclk) begin
    if (rst) begin
      state_q   <= RESET_PLL;
      cnt_q     <= '0;
      retry_q   <= '0;
      pll_rst_q <= 1'b1;
      dom_rst_q <= '1;
      ready_q   <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      retry_q   <= retry_d;
      pll_rst_q <= pll_rst_d;
      dom_rst_q <= dom_rst_d;
      ready_q   <= ready_d;
      fault_q   <= fault_d;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNT_W'(1);
    retry_d = retry_q;

    // A relock request anywhere, or losing lock once domains are being
    // released, starts a fresh sequence. Both at once give the same single
    // restart. In RESET_PLL this simply restarts the pulse.
    restart = relock_req ||
              (!lk && ((state_q == RELEASE) || (state_q == RUN)));

    if (restart) begin
      state_d = RESET_PLL;
      cnt_d   = '0;
      retry_d = '0;
    end else begin
      unique case (state_q)
        RESET_PLL: begin
          if (cnt_q == RST_LAST) begin
            state_d = WAIT_LOCK;
            cnt_d   = '0;
          end
        end
        WAIT_LOCK: begin
          if (lk) begin
            state_d = STABLE;
            cnt_d   = '0;
          end else if (cnt_q == TIMEOUT_LAST) begin
            // retry_q is always below MAX_RETRIES here, so this never wraps.
            retry_d = retry_q + RW'(1);
            cnt_d   = '0;
            state_d = (retry_d == RETRY_MAX) ? FAULT : RESET_PLL;
          end
        end
        STABLE: begin
          // A lock drop is not a failed attempt: go back to waiting with a
          // fresh timeout and no retry charged.
          if (!lk) begin
            state_d = WAIT_LOCK;
            cnt_d   = '0;
          end else if (cnt_q == STABLE_LAST) begin
            state_d = RELEASE;
            cnt_d   = '0;
          end
        end
        RELEASE: begin
          if (cnt_q == REL_LAST) begin
            state_d = RUN;
            cnt_d   = '0;
          end
        end
        RUN: begin
          cnt_d = '0;
        end
        FAULT: begin
          cnt_d = '0;
        end
        default: begin
          state_d = RESET_PLL;
          cnt_d   = '0;
          retry_d = '0;
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Output decode from the next state, registered above.
  // In RELEASE, domain i is released once the counter (cycles since entry)
  // reaches (i+1)*STAGGER_CYCLES; the last domain coincides with RUN.
  // -------------------------------------------------------------------------
  always_comb begin
    pll_rst_d = (state_d == RESET_PLL) || (state_d == FAULT);
    ready_d   = (state_d == RUN);
    fault_d   = (state_d == FAULT);
    dom_rst_d = '1;
    if (state_d == RUN) begin
      dom_rst_d = '0;
    end else if (state_d == RELEASE) begin
      for (int i = 0; i < NUM_DOMAINS; i++) begin
        dom_rst_d[i] = !(int'(cnt_d) >= (i + 1) * STAGGER_CYCLES);
      end
    end
  end

  assign pll_rst    = pll_rst_q;
  assign domain_rst = dom_rst_q;
  assign ready      = ready_q;
  assign fault      = fault_q;
  assign retry_cnt  = retry_q;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_pll_sys_lock_sequencer.sv
// ---------------------------------------------------------------------------
// tb_pll_sys_lock_sequencer
// Self-checking bench for pll_sys_lock_sequencer with small parameters.
// Every cycle the DUT outputs are compared to a behavioural model of the
// sequence (countdown timers and a two-entry lock history). On top of that a
// table of input segments with hand-derived end-of-segment outputs covers the
// directed scenarios, and a few hand-written sequences cover the glitch and
// relock-during-pulse corner cases, followed by randomized stimulus.
// ---------------------------------------------------------------------------
module tb_pll_sys_lock_sequencer;
  import pll_seq_pkg::*;

  localparam int ND      = 4;
  localparam int RSTP    = 4;
  localparam int TMO     = 20;
  localparam int STB     = 8;
  localparam int STG     = 2;
  localparam int MAXR    = 2;

  // ---------------- clock / reset / DUT ----------------
  logic          refclk;
  logic          rst;
  logic          pll_locked;
  logic          relock_req;
  logic          pll_rst;
  logic [ND-1:0] domain_rst;
  logic          ready;
  logic          fault;
  logic [1:0]    retry_cnt;
  state_e        state_dbg;

  initial refclk = 1'b0;
  always #5 refclk = ~refclk;

  pll_sys_lock_sequencer #(
    .NUM_DOMAINS         (ND),
    .RST_PULSE_CYCLES    (RSTP),
    .LOCK_TIMEOUT_CYCLES (TMO),
    .LOCK_STABLE_CYCLES  (STB),
    .STAGGER_CYCLES      (STG),
    .MAX_RETRIES         (MAXR)
  ) dut (
    .refclk     (refclk),
    .rst        (rst),
    .pll_locked (pll_locked),
    .relock_req (relock_req),
    .pll_rst    (pll_rst),
    .domain_rst (domain_rst),
    .ready      (ready),
    .fault      (fault),
    .retry_cnt  (retry_cnt),
    .state_dbg  (state_dbg)
  );

  // ---------------- scoreboard counters ----------------
  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d actual=%b expected=%b", name, cyc, act, exp);
    end
  endtask

  // Packed view: {pll_rst, domain_rst[3:0], ready, fault, retry_cnt[1:0]}
  function automatic logic [8:0] dut_vec();
    return {pll_rst, domain_rst, ready, fault, retry_cnt};
  endfunction

  // ---------------- behavioural reference model ----------------
  // Phases of the bring-up, tracked with countdowns rather than a shared
  // up-counter: remaining pulse cycles, remaining wait budget, remaining
  // locked cycles needed, and elapsed release time.
  localparam int PH_PULSE = 0, PH_WAIT = 1, PH_QUAL = 2,
                 PH_REL = 3, PH_RUN = 4, PH_FAULT = 5;
  int   m_phase;
  int   m_left;
  int   m_t;
  int   m_retries;
  logic m_hist[$];   // pll_locked as seen at the last two edges

  task automatic model_step(input logic r, input logic pl, input logic rq);
    logic lk;
    if (r) begin
      m_phase = PH_PULSE; m_left = RSTP; m_retries = 0; m_t = 0;
      m_hist = {1'b0, 1'b0};
      return;
    end
    lk = m_hist.pop_front();
    m_hist.push_back(pl);
    if (rq || (!lk && (m_phase == PH_REL || m_phase == PH_RUN))) begin
      m_phase = PH_PULSE; m_left = RSTP; m_retries = 0;
      return;
    end
    case (m_phase)
      PH_PULSE: begin
        m_left--;
        if (m_left == 0) begin m_phase = PH_WAIT; m_left = TMO; end
      end
      PH_WAIT: begin
        if (lk) begin
          m_phase = PH_QUAL; m_left = STB;
        end else begin
          m_left--;
          if (m_left == 0) begin
            m_retries++;
            if (m_retries == MAXR) m_phase = PH_FAULT;
            else begin m_phase = PH_PULSE; m_left = RSTP; end
          end
        end
      end
      PH_QUAL: begin
        if (!lk) begin
          m_phase = PH_WAIT; m_left = TMO;
        end else begin
          m_left--;
          if (m_left == 0) begin m_phase = PH_REL; m_t = 0; end
        end
      end
      PH_REL: begin
        m_t++;
        if (m_t == ND * STG) m_phase = PH_RUN;
      end
      default: ;
    endcase
  endtask

  function automatic logic [8:0] model_vec();
    logic          p;
    logic [ND-1:0] d;
    p = (m_phase == PH_PULSE) || (m_phase == PH_FAULT);
    d = '1;
    if (m_phase == PH_RUN) d = '0;
    if (m_phase == PH_REL)
      for (int i = 0; i < ND; i++) d[i] = !(m_t >= (i + 1) * STG);
    return {p, d, logic'(m_phase == PH_RUN), logic'(m_phase == PH_FAULT),
            2'(m_retries)};
  endfunction

  // ---------------- driver ----------------
  task automatic tick(input logic r, input logic pl, input logic rq);
    rst = r; pll_locked = pl; relock_req = rq;
    @(posedge refclk);
    model_step(r, pl, rq);
    cyc++;
    #1;
    check("model", dut_vec(), model_vec());
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    string      name;
    logic       r;
    logic       pl;
    logic       rq;      // asserted on the first cycle of the segment only
    int         cycles;
    logic [8:0] exp;     // {pll_rst, domain_rst, ready, fault, retry_cnt}
  } vec_t;

  vec_t vecs[$];

  initial begin
    logic pl_r;
    vecs.push_back('{"reset",        1'b1, 1'b0, 1'b0,  3, 9'b1_1111_0_0_00});
    vecs.push_back('{"clean_bringup",1'b0, 1'b1, 1'b0, 30, 9'b0_0000_1_0_00});
    vecs.push_back('{"lol_in_run",   1'b0, 1'b0, 1'b0,  3, 9'b1_1111_0_0_00});
    vecs.push_back('{"fault_stuck0", 1'b0, 1'b0, 1'b0, 60, 9'b1_1111_0_1_10});
    vecs.push_back('{"relock_fault", 1'b0, 1'b1, 1'b1,  1, 9'b1_1111_0_0_00});
    vecs.push_back('{"fault_recover",1'b0, 1'b1, 1'b0, 30, 9'b0_0000_1_0_00});
    vecs.push_back('{"reset2",       1'b1, 1'b0, 1'b0,  1, 9'b1_1111_0_0_00});
    vecs.push_back('{"timeout_once", 1'b0, 1'b0, 1'b0, 24, 9'b1_1111_0_0_01});
    vecs.push_back('{"lock_2nd_try", 1'b0, 1'b1, 1'b0, 30, 9'b0_0000_1_0_01});
    vecs.push_back('{"reset3",       1'b1, 1'b1, 1'b0,  1, 9'b1_1111_0_0_00});
    vecs.push_back('{"mid_release",  1'b0, 1'b1, 1'b0, 17, 9'b0_1100_0_0_00});
    vecs.push_back('{"rst_in_rel",   1'b1, 1'b1, 1'b0,  1, 9'b1_1111_0_0_00});

    rst = 1'b1; pll_locked = 1'b0; relock_req = 1'b0;

    for (int v = 0; v < vecs.size(); v++) begin
      for (int k = 0; k < vecs[v].cycles; k++)
        tick(vecs[v].r, vecs[v].pl, vecs[v].rq && (k == 0));
      check(vecs[v].name, dut_vec(), vecs[v].exp);
    end

    // Lock glitch while qualifying: low for edges 9..11 (seen by the FSM at
    // 11..13). Qualification must restart, so release begins at edge 22.
    tick(1'b1, 1'b0, 1'b0);
    for (int e = 1; e <= 24; e++) begin
      tick(1'b0, logic'((e <= 8) || (e >= 12)), 1'b0);
      if (e == 21) check("glitch_no_early_release", dut_vec(), 9'b0_1111_0_0_00);
      if (e == 24) check("glitch_first_release",    dut_vec(), 9'b0_1110_0_0_00);
    end

    // Relock request during the PLL reset pulse restarts the pulse count.
    tick(1'b1, 1'b0, 1'b0);
    for (int e = 1; e <= 7; e++) begin
      tick(1'b0, 1'b1, logic'(e == 3));
      if (e == 6) check("relock_pulse_held",  {8'd0, pll_rst}, 9'd1);
      if (e == 7) check("relock_pulse_ended", {8'd0, pll_rst}, 9'd0);
    end

    // Randomized stimulus: lock level with long runs, rare relock and reset.
    pl_r = 1'b1;
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(59, 0) == 0) pl_r = ~pl_r;
      tick(logic'($urandom_range(1499, 0) == 0), pl_r,
           logic'($urandom_range(249, 0) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
